// File: rtl/seg_pkg.sv
// Shared constants and state encoding for the seven-segment scan controller.
// Defaults describe a 4-digit display lit for 1000 cycles per digit.
package seg_pkg;

  localparam int unsigned NibbleW        = 4;
  localparam int unsigned DefNumDigits   = 4;
  localparam int unsigned DefRefreshDiv  = 1000;
  localparam int unsigned DefBlankCycles = 2;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StBlank = 2'd1,
    StShow  = 2'd2
  } scan_state_e;

endpackage

// File: rtl/seg_scan_timer.sv
// Loadable down-counter; tc_o is high while the count sits at zero.
// Loading N-1 on entry to an interval gives an interval of N cycles.
module seg_scan_timer #(
  parameter int unsigned Width = 4
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             load_i,
  input  logic [Width-1:0] load_val_i,
  output logic             tc_o
);

  logic [Width-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - Width'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign tc_o = (cnt_q == '0);

endmodule

// File: rtl/seg_scan_ctrl.sv
// Time-multiplexed scan controller sharing one nibble decoder across all digits.
// Host writes land in a shadow register and reach the display only at frame boundaries.
module seg_scan_ctrl import seg_pkg::*; #(
  parameter int unsigned NumDigits   = DefNumDigits,
  parameter int unsigned RefreshDiv  = DefRefreshDiv,
  parameter int unsigned BlankCycles = DefBlankCycles
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  input  logic                         en_i,
  input  logic                         load_i,
  input  logic [NibbleW*NumDigits-1:0] data_in_i,
  input  logic [NumDigits-1:0]         blank_mask_i,
  output logic [NibbleW-1:0]           nibble_o,
  output logic [NumDigits-1:0]         digit_sel_o,
  output logic                         frame_done_o,
  output logic                         pending_o
);

  localparam int unsigned DataW  = NibbleW * NumDigits;
  localparam int unsigned IdxW   = $clog2(NumDigits);
  localparam int unsigned CntMax = (RefreshDiv > BlankCycles) ? RefreshDiv : BlankCycles;
  localparam int unsigned CntW   = (CntMax > 1) ? $clog2(CntMax) : 1;

  localparam logic [CntW-1:0]      ShowLoad  = CntW'(RefreshDiv - 1);
  localparam logic [CntW-1:0]      BlankLoad = CntW'(BlankCycles - 1);
  localparam logic [IdxW-1:0]      LastIdx   = IdxW'(NumDigits - 1);
  localparam logic [NumDigits-1:0] SelLsb    = NumDigits'(1);

  scan_state_e                             state_q, state_d;
  logic [IdxW-1:0]                         idx_q, idx_d;
  logic [DataW-1:0]                        shadow_q, shadow_d;
  logic [NumDigits-1:0][NibbleW-1:0]       active_q, active_d;
  logic                                    pending_q, pending_d;
  logic [NibbleW-1:0]                      nibble_q, nibble_d;
  logic [NumDigits-1:0]                    digit_sel_q, digit_sel_d;
  logic                                    frame_done_q, frame_done_d;

  logic            tmr_load, tmr_tc;
  logic [CntW-1:0] tmr_val;
  logic            xfer, enter_blank;

  seg_scan_timer #(
    .Width (CntW)
  ) u_timer (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .load_i     (tmr_load),
    .load_val_i (tmr_val),
    .tc_o       (tmr_tc)
  );

  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    shadow_d     = shadow_q;
    active_d     = active_q;
    pending_d    = pending_q;
    nibble_d     = nibble_q;
    digit_sel_d  = digit_sel_q;
    frame_done_d = 1'b0;
    tmr_load     = 1'b0;
    tmr_val      = BlankLoad;
    xfer         = 1'b0;
    enter_blank  = 1'b0;

    if (load_i) begin
      shadow_d  = data_in_i;
      pending_d = 1'b1;
    end

    if (!en_i) begin
      state_d     = StIdle;
      idx_d       = '0;
      digit_sel_d = '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          idx_d       = '0;
          xfer        = 1'b1;
          enter_blank = 1'b1;
        end
        StBlank: begin
          if (tmr_tc) begin
            state_d     = StShow;
            tmr_load    = 1'b1;
            tmr_val     = ShowLoad;
            digit_sel_d = (SelLsb << idx_q) & ~blank_mask_i;
          end
        end
        StShow: begin
          // Mask is re-sampled every lit cycle so changes show up one cycle later.
          digit_sel_d = (SelLsb << idx_q) & ~blank_mask_i;
          if (tmr_tc) begin
            enter_blank = 1'b1;
            if (idx_q == LastIdx) begin
              idx_d        = '0;
              frame_done_d = 1'b1;
              xfer         = 1'b1;
            end else begin
              idx_d = idx_q + IdxW'(1);
            end
          end
        end
        default: state_d = StIdle;
      endcase
    end

    if (enter_blank) begin
      state_d     = StBlank;
      digit_sel_d = '0;
      tmr_load    = 1'b1;
      tmr_val     = BlankLoad;
    end

    // A load coinciding with a frame boundary bypasses the shadow.
    if (xfer) begin
      if (load_i) begin
        active_d  = data_in_i;
        pending_d = 1'b0;
      end else if (pending_q) begin
        active_d  = shadow_q;
        pending_d = 1'b0;
      end
    end

    if (enter_blank) begin
      nibble_d = active_d[idx_d];
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q      <= StIdle;
      idx_q        <= '0;
      shadow_q     <= '0;
      active_q     <= '0;
      pending_q    <= 1'b0;
      nibble_q     <= '0;
      digit_sel_q  <= '0;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      shadow_q     <= shadow_d;
      active_q     <= active_d;
      pending_q    <= pending_d;
      nibble_q     <= nibble_d;
      digit_sel_q  <= digit_sel_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign nibble_o     = nibble_q;
  assign digit_sel_o  = digit_sel_q;
  assign frame_done_o = frame_done_q;
  assign pending_o    = pending_q;

endmodule
